// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control-step sequencer.
// Holds the state enum, opcode constants, IR field positions and the opcode legality check.
// Optional feature macro: MULDIV_HILO_EN adds the MUL/DIV path and state T6.
package alu_ctrl_pkg;

   localparam int OPC_W  = 5;
   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   localparam logic [OPC_W-1:0] OP_ADD = 5'd3;
   localparam logic [OPC_W-1:0] OP_SUB = 5'd4;
   localparam logic [OPC_W-1:0] OP_SHR = 5'd5;
   localparam logic [OPC_W-1:0] OP_SHL = 5'd6;
   localparam logic [OPC_W-1:0] OP_ROR = 5'd7;
   localparam logic [OPC_W-1:0] OP_ROL = 5'd8;
   localparam logic [OPC_W-1:0] OP_AND = 5'd9;
   localparam logic [OPC_W-1:0] OP_OR  = 5'd10;
   localparam logic [OPC_W-1:0] OP_NEG = 5'd11;
   localparam logic [OPC_W-1:0] OP_NOT = 5'd12;
   localparam logic [OPC_W-1:0] OP_MUL = 5'd13;
   localparam logic [OPC_W-1:0] OP_DIV = 5'd14;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
`ifdef MULDIV_HILO_EN
      S_T5,
      S_T6
`else
      S_T5
`endif
   } state_t;

   function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
`ifdef MULDIV_HILO_EN
      return ((op >= OP_ADD) && (op <= OP_NOT)) || is_muldiv(op);
`else
      return (op >= OP_ADD) && (op <= OP_NOT);
`endif
   endfunction

endpackage

// File: rtl/alu_ctrl_sequencer_dec.sv
// Binary register select to one-hot register strobe vector.
// Ports: i_sel (REG_SEL_W) register number, o_onehot (NUM_REGS) one-hot result.
module reg_onehot_dec #(
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4
) (
   input  logic [REG_SEL_W-1:0] i_sel,
   output logic [NUM_REGS-1:0]  o_onehot
);

   always_comb begin
      o_onehot        = '0;
      o_onehot[i_sel] = 1'b1;
   end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Hardwired control-step sequencer: fetch T0-T2, then Rb->Y, Rc op Y->Z, Z->Ra.
// Ports: i_clk, i_rst (sync, high), i_start, i_mem_ready, i_ir_data; bus/load strobes,
//   o_rout/o_rin one-hot, o_alu_sel, o_busy, o_done, o_illegal_op (all registered).
// Optional feature macro: MULDIV_HILO_EN (MUL/DIV legal, LO in T5, HI in T6).
module alu_ctrl_sequencer #(
   parameter int DATA_W    = 32,
   parameter int NUM_REGS  = 16,
   parameter int REG_SEL_W = 4,
   parameter int OPCODE_W  = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   input  logic                 i_mem_ready,
   input  logic [DATA_W-1:0]    i_ir_data,
   output logic                 o_pc_out,
   output logic                 o_mar_in,
   output logic                 o_inc_pc,
   output logic                 o_pc_in,
   output logic                 o_read,
   output logic                 o_mdr_in,
   output logic                 o_mdr_out,
   output logic                 o_ir_in,
   output logic                 o_y_in,
   output logic                 o_z_in,
   output logic                 o_zlow_out,
   output logic                 o_zhigh_out,
   output logic                 o_hi_in,
   output logic                 o_lo_in,
   output logic [NUM_REGS-1:0]  o_rout,
   output logic [NUM_REGS-1:0]  o_rin,
   output logic [OPCODE_W-1:0]  o_alu_sel,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_illegal_op
);
   import alu_ctrl_pkg::*;

   state_t                r_state;
   logic                  r_pc_out, r_mar_in, r_inc_pc, r_pc_in;
   logic                  r_read, r_mdr_in, r_mdr_out, r_ir_in;
   logic                  r_y_in, r_z_in, r_zlow_out;
   logic [NUM_REGS-1:0]   r_rout, r_rin;
   logic [OPCODE_W-1:0]   r_alu_sel;
   logic                  r_busy, r_done, r_illegal;

   logic [OPCODE_W-1:0]   w_opcode;
   logic [REG_SEL_W-1:0]  w_ra, w_rb, w_rc, w_rout_sel;
   logic [NUM_REGS-1:0]   w_rout_oh, w_rin_oh;
   logic                  w_legal;
   logic                  w_unused_ir;

   assign w_opcode    = i_ir_data[OPC_MSB:OPC_LSB];
   assign w_ra        = i_ir_data[RA_MSB:RA_LSB];
   assign w_rb        = i_ir_data[RB_MSB:RB_LSB];
   assign w_rc        = i_ir_data[RC_MSB:RC_LSB];
   assign w_legal     = is_alu_op(w_opcode);
   assign w_unused_ir = ^i_ir_data[RC_LSB-1:0];

   // Leaving T2 loads Rb for T3; leaving T3 loads Rc for T4.
   assign w_rout_sel = (r_state == S_T2) ? w_rb : w_rc;

   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rout_dec (
      .i_sel    (w_rout_sel),
      .o_onehot (w_rout_oh)
   );

   reg_onehot_dec #(.NUM_REGS(NUM_REGS), .REG_SEL_W(REG_SEL_W)) u_rin_dec (
      .i_sel    (w_ra),
      .o_onehot (w_rin_oh)
   );

`ifdef MULDIV_HILO_EN
   logic r_zhigh_out, r_hi_in, r_lo_in;
   logic w_muldiv;
   assign w_muldiv = is_muldiv(w_opcode);
`endif

   // Outputs are loaded with the decode of the state being entered.
   // In T1, r_pc_in doubles as the "memory ready, last T1 cycle" flag.
   always_ff @(posedge i_clk) begin
      r_pc_out   <= 1'b0;
      r_mar_in   <= 1'b0;
      r_inc_pc   <= 1'b0;
      r_pc_in    <= 1'b0;
      r_read     <= 1'b0;
      r_mdr_in   <= 1'b0;
      r_mdr_out  <= 1'b0;
      r_ir_in    <= 1'b0;
      r_y_in     <= 1'b0;
      r_z_in     <= 1'b0;
      r_zlow_out <= 1'b0;
      r_rout     <= '0;
      r_rin      <= '0;
      r_alu_sel  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
`ifdef MULDIV_HILO_EN
      r_zhigh_out <= 1'b0;
      r_hi_in     <= 1'b0;
      r_lo_in     <= 1'b0;
`endif
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state  <= S_T0;
                  r_busy   <= 1'b1;
                  r_pc_out <= 1'b1;
                  r_mar_in <= 1'b1;
                  r_inc_pc <= 1'b1;
                  r_z_in   <= 1'b1;
               end
            end
            S_T0, S_T1: begin
               if ((r_state == S_T1) && r_pc_in) begin
                  r_state   <= S_T2;
                  r_busy    <= 1'b1;
                  r_mdr_out <= 1'b1;
                  r_ir_in   <= 1'b1;
               end else begin
                  r_state    <= S_T1;
                  r_busy     <= 1'b1;
                  r_zlow_out <= 1'b1;
                  r_read     <= 1'b1;
                  r_mdr_in   <= 1'b1;
                  r_pc_in    <= i_mem_ready;
               end
            end
            S_T2: begin
               r_state <= S_T3;
               r_busy  <= 1'b1;
               if (w_legal) begin
                  r_rout <= w_rout_oh;
                  r_y_in <= 1'b1;
               end else begin
                  r_illegal <= 1'b1;
               end
            end
            S_T3: begin
               if (w_legal) begin
                  r_state   <= S_T4;
                  r_busy    <= 1'b1;
                  r_rout    <= w_rout_oh;
                  r_z_in    <= 1'b1;
                  r_alu_sel <= w_opcode;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_T4: begin
               r_state    <= S_T5;
               r_busy     <= 1'b1;
               r_zlow_out <= 1'b1;
`ifdef MULDIV_HILO_EN
               if (w_muldiv) begin
                  r_lo_in <= 1'b1;
               end else begin
                  r_rin  <= w_rin_oh;
                  r_done <= 1'b1;
               end
`else
               r_rin  <= w_rin_oh;
               r_done <= 1'b1;
`endif
            end
`ifdef MULDIV_HILO_EN
            S_T5: begin
               if (w_muldiv) begin
                  r_state     <= S_T6;
                  r_busy      <= 1'b1;
                  r_zhigh_out <= 1'b1;
                  r_hi_in     <= 1'b1;
                  r_done      <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_T6: r_state <= S_IDLE;
`else
            S_T5: r_state <= S_IDLE;
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_pc_out     = r_pc_out;
   assign o_mar_in     = r_mar_in;
   assign o_inc_pc     = r_inc_pc;
   assign o_pc_in      = r_pc_in;
   assign o_read       = r_read;
   assign o_mdr_in     = r_mdr_in;
   assign o_mdr_out    = r_mdr_out;
   assign o_ir_in      = r_ir_in;
   assign o_y_in       = r_y_in;
   assign o_z_in       = r_z_in;
   assign o_zlow_out   = r_zlow_out;
   assign o_rout       = r_rout;
   assign o_rin        = r_rin;
   assign o_alu_sel    = r_alu_sel;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_illegal_op = r_illegal;
`ifdef MULDIV_HILO_EN
   assign o_zhigh_out  = r_zhigh_out;
   assign o_hi_in      = r_hi_in;
   assign o_lo_in      = r_lo_in;
`else
   assign o_zhigh_out  = 1'b0;
   assign o_hi_in      = 1'b0;
   assign o_lo_in      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer.
// Per-cycle expected strobe vectors are built from the instruction fields and memory wait count.
module tb_alu_ctrl_sequencer;

   typedef struct packed {
      logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
      logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
      logic [15:0] rout, rin;
      logic [4:0]  alu_sel;
      logic        busy, done, illegal;
   } ov_t;

   logic        clk = 1'b0;
   logic        rst, start, mem_ready;
   logic [31:0] ir_data;
   logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
   logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
   logic [15:0] rout, rin;
   logic [4:0]  alu_sel;
   logic        busy, done, illegal;
   ov_t         obs;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_ctrl_sequencer dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_mem_ready(mem_ready),
      .i_ir_data(ir_data),
      .o_pc_out(pc_out), .o_mar_in(mar_in), .o_inc_pc(inc_pc), .o_pc_in(pc_in),
      .o_read(read), .o_mdr_in(mdr_in), .o_mdr_out(mdr_out), .o_ir_in(ir_in),
      .o_y_in(y_in), .o_z_in(z_in), .o_zlow_out(zlow_out),
      .o_zhigh_out(zhigh_out), .o_hi_in(hi_in), .o_lo_in(lo_in),
      .o_rout(rout), .o_rin(rin), .o_alu_sel(alu_sel),
      .o_busy(busy), .o_done(done), .o_illegal_op(illegal)
   );

   assign obs = {pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
                 y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in,
                 rout, rin, alu_sel, busy, done, illegal};

`ifdef MULDIV_HILO_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic st, input logic rdy, input logic rs);
      start     = st;
      mem_ready = rdy;
      rst       = rs;
      @(posedge clk);
      @(negedge clk);
   endtask

   // abort_at: -1 none, >=0 reset on that step, 999 random 15% chance.
   task automatic run_inst(input logic [31:0] ir, input int w, input int gap,
                           input int abort_at, input string tag);
      ov_t        q[$];
      logic       rq[$];
      ov_t        e;
      logic [4:0] op;
      int         ra, rb, rc, ab;
      bit         md, legal;
      op    = ir[31:27];
      ra    = int'(ir[26:23]);
      rb    = int'(ir[22:19]);
      rc    = int'(ir[18:15]);
      md    = MD_EN && (op == 5'd13 || op == 5'd14);
      legal = (op >= 5'd3 && op <= 5'd12) || md;
      e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
      q.push_back(e); rq.push_back(1'($urandom));
      for (int k = 0; k <= w; k++) begin
         e = '0; e.busy = 1; e.zlow_out = 1; e.read = 1; e.mdr_in = 1;
         e.pc_in = (k == w);
         q.push_back(e); rq.push_back(k == w);
      end
      e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
      q.push_back(e); rq.push_back(1'($urandom));
      if (!legal) begin
         e = '0; e.busy = 1; e.illegal = 1;
         q.push_back(e); rq.push_back(1'($urandom));
      end else begin
         e = '0; e.busy = 1; e.y_in = 1; e.rout = 16'(1) << rb;
         q.push_back(e); rq.push_back(1'($urandom));
         e = '0; e.busy = 1; e.z_in = 1; e.rout = 16'(1) << rc; e.alu_sel = op;
         q.push_back(e); rq.push_back(1'($urandom));
         e = '0; e.busy = 1; e.zlow_out = 1;
         if (md) e.lo_in = 1;
         else begin e.rin = 16'(1) << ra; e.done = 1; end
         q.push_back(e); rq.push_back(1'($urandom));
         if (md) begin
            e = '0; e.busy = 1; e.zhigh_out = 1; e.hi_in = 1; e.done = 1;
            q.push_back(e); rq.push_back(1'($urandom));
         end
      end
      e = '0;
      q.push_back(e); rq.push_back(1'($urandom));
      ab = abort_at;
      if (ab == 999)
         ab = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, q.size() - 1)) : -1;
      ir_data = ir;
      for (int g = 0; g < gap; g++) begin
         tick(1'b0, 1'($urandom), 1'b0);
         check($sformatf("%s.idle%0d", tag, g), 64'(obs), 64'(0));
      end
      for (int i = 0; i < q.size(); i++) begin
         tick(i == 0, rq[i], i == ab);
         if (i == ab) begin
            check($sformatf("%s.rst%0d", tag, i), 64'(obs), 64'(0));
            break;
         end
         check($sformatf("%s.c%0d", tag, i), 64'(obs), 64'(q[i]));
      end
   endtask

   initial begin
      logic [31:0] ir;
      logic [4:0]  op;
      ir_data = 32'h0;
      tick(1'b0, 1'b0, 1'b1);
      check("reset0", 64'(obs), 64'(0));
      tick(1'b1, 1'b1, 1'b1);
      check("reset1", 64'(obs), 64'(0));
      tick(1'b0, 1'b1, 1'b0);
      check("idle", 64'(obs), 64'(0));

      run_inst(32'h4A920000, 0, 1, -1, "and");
      run_inst(32'h4A920000, 3, 1, -1, "wait3");
      run_inst(32'hF8000000, 1, 1, -1, "ill31");
      run_inst(32'h4A920000, 0, 1, 5, "rstT4");
      run_inst({5'd13, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1, -1, "mul");
      run_inst({5'd14, 4'd0, 4'd7, 4'd7, 15'd0}, 2, 0, -1, "div");
      run_inst({5'd3, 4'd0, 4'd6, 4'd6, 15'd0}, 0, 1, -1, "ra0");
      run_inst({5'd4, 4'd9, 4'd9, 4'd1, 15'd0}, 0, 0, -1, "b2b");

      for (int n = 0; n < 60; n++) begin
         op = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(3, 14))
                                         : 5'($urandom);
         ir = {op, 27'($urandom)};
         run_inst(ir, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                  999, $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
